decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction-decode stage of the 5-stage pipeline: IF → ID → EX → MEM → WB.
- Holds the 32x32 general register file, with its write port driven by WB.
- Decodes IR_D into operand and immediate values, detects load-use hazards, and latches results into the ID/EX pipeline register.
- The ID/EX register directly feeds the excute stage through IR_E, NPC_E, A_E, B_E and Imm_E.

Parameters:
- NREG, 32, number of architectural registers (5-bit index); r0 reads as zero.
- NOP_IR, 32'h00000000, bubble instruction injected into IR_E (op 000000, no effect in EX).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- IR_D  input  32  instruction from the IF/ID register.
- NPC_D  input  32  PC+4 of IR_D.
- flush  input  1  taken branch/jump (Cond from EX); IR_D is wrong-path.
- WB_en  input  1  register-file write enable from WB.
- WB_addr  input  5  register-file write index.
- WB_data  input  32  register-file write data.
- stall_D  output  1  combinational; IF and IF/ID hold while this is high.
- IR_E  output  32  registered instruction to EX.
- NPC_E  output  32  registered NPC to EX.
- A_E  output  32  registered rs value.
- B_E  output  32  registered rt value.
- Imm_E  output  32  registered immediate.

Behaviour:
- Fields of IR_D:
  - op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11].
  - Opcodes: 000001–000110 ADD/SUB/AND/OR/XOR/SLT; 001000 LW; 001001 SW; 001010 BEQ; 001011 JUMP.
  - Any other op is a NOP.
- Source usage:
  - ALU ops read rs and rt.
  - SW reads rs and rt.
  - LW reads rs only.
  - BEQ reads rs only.
  - JUMP and NOP read none.
- Immediate generation:
  - JUMP: Imm = {6'b0, IR_D[25:0]}.
  - All other ops: Imm = {{16{IR_D[15]}}, IR_D[15:0]}.
- Register file:
  - Read is asynchronous.
  - Reading index 0 returns 0.
  - Writes occur on the clock edge when WB_en=1 and WB_addr≠0; writes to r0 are ignored.
- WB bypass: if WB_en=1, WB_addr≠0 and WB_addr equals the read index in the same cycle, the read returns WB_data (write-before-read).
- Load-use hazard:
  - stall_D = (IR_E op == LW) && (IR_E rt ≠ 0) && ((rs used && rs == IR_E rt) || (rt used && rt == IR_E rt)).
  - stall_D is forced to 0 when flush=1 or reset=1.
- ID/EX register update, one per clock edge, in priority order:
  1. reset: IR_E=NOP_IR; NPC_E, A_E, B_E, Imm_E = 0; all register-file entries = 0.
  2. flush: IR_E=NOP_IR; A_E, B_E, Imm_E, NPC_E = 0.
  3. stall_D: IR_E=NOP_IR (bubble); other fields = 0.
  4. Otherwise: IR_E=IR_D, NPC_E=NPC_D, A_E=R[rs], B_E=R[rt], Imm_E=Imm.
- A WB write is still performed on a flush or stall cycle; it is suppressed only by reset.
- Latency: one cycle from IR_D to IR_E. stall_D produces exactly one bubble per load-use pair, because the next cycle IR_E is a NOP and stall_D drops.
- Reset asserted mid-operation clears the pipeline register and the register file on that edge, with no partial update.

Test Plan:
- Reset: hold reset 2 cycles with WB_en=1, WB_addr=5 → IR_E=0, A_E=B_E=Imm_E=NPC_E=0, and R5 still reads 0 afterwards.
- Basic decode:
  - Stimulus: preload R1=10, R2=3 via WB; IR_D = ADD rs=1, rt=2, rd=3; NPC_D=0x104.
  - Response: next cycle IR_E=IR_D, A_E=10, B_E=3, NPC_E=0x104, stall_D=0.
- Immediates: LW with IR_D[15:0]=0xFFFC → Imm_E=0xFFFFFFFC; JUMP with IR_D[25:0]=0x0000040 → Imm_E=0x00000040.
- Bypass and r0:
  - Same-cycle WB_en=1, WB_addr=7, WB_data=0xDEAD while IR_D reads rs=7 → A_E=0xDEAD.
  - WB to r0 with data 0x55, then read r0 → A_E=0.
- Load-use:
  - IR_E=LW rt=4 and IR_D=SUB rs=4 → stall_D=1 and IR_E becomes NOP.
  - Next cycle, SUB issues with operands from R4.
  - IR_D=JUMP behind LW rt=4 → stall_D=0.
- Flush: flush=1 together with a load-use condition → stall_D=0, IR_E=NOP next cycle, and a pending WB write in the same cycle still commits.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: ID stage (clk, reset | IR_D, NPC_D, flush, WB_en/addr/data -> stall_D, IR_E, NPC_E, A_E, B_E, Imm_E), 32x32 regfile with WB bypass, load-use stall, ID/EX register
module decode_stage #(
  parameter int          NREG   = 32,
  parameter logic [31:0] NOP_IR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] NPC_D,
  input  logic        flush,
  input  logic        WB_en,
  input  logic [4:0]  WB_addr,
  input  logic [31:0] WB_data,
  output logic        stall_D,
  output logic [31:0] IR_E,
  output logic [31:0] NPC_E,
  output logic [31:0] A_E,
  output logic [31:0] B_E,
  output logic [31:0] Imm_E
);
  localparam logic [5:0] OP_LW = 6'b001000, OP_SW = 6'b001001, OP_BEQ = 6'b001010, OP_JMP = 6'b001011;
  logic [31:0] rf_q [NREG];
  logic [31:0] ir_e_q, npc_e_q, a_e_q, b_e_q, imm_e_q;
  logic [31:0] ir_e_d, npc_e_d, a_e_d, b_e_d, imm_e_d;
  logic [31:0] rs_val, rt_val, imm;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rt_e;
  logic        alu, rs_used, rt_used, wb_wr, kill;
  assign op      = IR_D[31:26];
  assign rs      = IR_D[25:21];
  assign rt      = IR_D[20:16];
  assign rt_e    = ir_e_q[20:16];
  assign alu     = op >= 6'd1 && op <= 6'd6;
  assign rs_used = alu || op == OP_LW || op == OP_SW || op == OP_BEQ;
  assign rt_used = alu || op == OP_SW;
  assign wb_wr   = WB_en && WB_addr != 5'd0;
  assign rs_val  = rs == 5'd0 ? '0 : wb_wr && WB_addr == rs ? WB_data : rf_q[rs];
  assign rt_val  = rt == 5'd0 ? '0 : wb_wr && WB_addr == rt ? WB_data : rf_q[rt];
  assign imm     = op == OP_JMP ? {6'b0, IR_D[25:0]} : {{16{IR_D[15]}}, IR_D[15:0]};
  assign stall_D = !reset && !flush && ir_e_q[31:26] == OP_LW && rt_e != 5'd0 &&
                   ((rs_used && rs == rt_e) || (rt_used && rt == rt_e));
  assign kill    = flush || stall_D;
  always_comb begin
    ir_e_d  = kill ? NOP_IR : IR_D;
    npc_e_d = kill ? '0 : NPC_D;
    a_e_d   = kill ? '0 : rs_val;
    b_e_d   = kill ? '0 : rt_val;
    imm_e_d = kill ? '0 : imm;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_e_q  <= NOP_IR;
      npc_e_q <= '0;
      a_e_q   <= '0;
      b_e_q   <= '0;
      imm_e_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      ir_e_q  <= ir_e_d;
      npc_e_q <= npc_e_d;
      a_e_q   <= a_e_d;
      b_e_q   <= b_e_d;
      imm_e_q <= imm_e_d;
      if (wb_wr) rf_q[WB_addr] <= WB_data;
    end
  end
  assign IR_E  = ir_e_q;
  assign NPC_E = npc_e_q;
  assign A_E   = a_e_q;
  assign B_E   = b_e_q;
  assign Imm_E = imm_e_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized scoreboard bench for decode_stage against a spec-level model
module tb_decode_stage;
  logic        clk = 0, reset = 1, flush = 0, WB_en = 0;
  logic [31:0] IR_D = 0, NPC_D = 0, WB_data = 0;
  logic [4:0]  WB_addr = 0;
  logic        stall_D;
  logic [31:0] IR_E, NPC_E, A_E, B_E, Imm_E;
  typedef struct {logic stall; logic [31:0] ir, npc, a, b, imm;} exp_t;
  exp_t        q[$];
  logic [31:0] mrf [32];
  logic [31:0] mir_e = 0;
  int          n_cmp = 0, n_err = 0;
  decode_stage dut (
    .clk(clk), .reset(reset), .IR_D(IR_D), .NPC_D(NPC_D), .flush(flush),
    .WB_en(WB_en), .WB_addr(WB_addr), .WB_data(WB_data), .stall_D(stall_D),
    .IR_E(IR_E), .NPC_E(NPC_E), .A_E(A_E), .B_E(B_E), .Imm_E(Imm_E)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] lo);
    return {op, rs, rt, lo};
  endfunction
  function automatic logic [31:0] rdm(input logic [4:0] i, input logic w, input logic [4:0] wa, input logic [31:0] wd);
    if (i == 0) return 0;
    if (w && wa == i) return wd;
    return mrf[i];
  endfunction
  task automatic step(input logic r, input logic [31:0] ir, npc, input logic f, w, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    int op, ope;
    logic us, ut;
    @(negedge clk);
    reset = r; IR_D = ir; NPC_D = npc; flush = f; WB_en = w; WB_addr = wa; WB_data = wd;
    op  = int'(ir[31:26]);
    ope = int'(mir_e[31:26]);
    us  = (op >= 1 && op <= 6) || op == 8 || op == 9 || op == 10;
    ut  = (op >= 1 && op <= 6) || op == 9;
    e.stall = !r && !f && ope == 8 && mir_e[20:16] != 0 &&
              ((us && ir[25:21] == mir_e[20:16]) || (ut && ir[20:16] == mir_e[20:16]));
    if (r || f || e.stall) begin
      e.ir = 0; e.npc = 0; e.a = 0; e.b = 0; e.imm = 0;
    end else begin
      e.ir  = ir;
      e.npc = npc;
      e.a   = rdm(ir[25:21], w, wa, wd);
      e.b   = rdm(ir[20:16], w, wa, wd);
      e.imm = op == 11 ? {6'b0, ir[25:0]} : {{16{ir[15]}}, ir[15:0]};
    end
    q.push_back(e);
    if (r) for (int i = 0; i < 32; i++) mrf[i] = 0;
    else if (w && wa != 0) mrf[wa] = wd;
    mir_e = e.ir;
  endtask
  task automatic chk(input string name, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  initial begin : monitor
    exp_t e;
    logic s;
    forever begin
      @(negedge clk);
      #2 s = stall_D;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_D", {31'b0, s}, {31'b0, e.stall});
        chk("IR_E", IR_E, e.ir);
        chk("NPC_E", NPC_E, e.npc);
        chk("A_E", A_E, e.a);
        chk("B_E", B_E, e.b);
        chk("Imm_E", Imm_E, e.imm);
      end
    end
  end
  initial begin : driver
    logic [5:0] op;
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    step(1, 0, 0, 0, 1, 5, 32'h1234);
    step(1, 0, 0, 0, 1, 5, 32'h1234);
    step(0, ins(1, 5, 0, 0), 32'h100, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 10);
    step(0, 0, 0, 0, 1, 2, 3);
    step(0, ins(1, 1, 2, 16'h1800), 32'h104, 0, 0, 0, 0);
    step(0, ins(8, 1, 4, 16'hFFFC), 32'h108, 0, 1, 4, 32'h44);
    step(0, ins(2, 4, 2, 0), 32'h10C, 0, 0, 0, 0);
    step(0, ins(2, 4, 2, 0), 32'h10C, 0, 0, 0, 0);
    step(0, ins(8, 1, 4, 0), 32'h110, 0, 0, 0, 0);
    step(0, ins(11, 0, 0, 16'h0040), 32'h114, 0, 0, 0, 0);
    step(0, ins(1, 7, 0, 0), 32'h118, 0, 1, 7, 32'hDEAD);
    step(0, 0, 0, 0, 1, 0, 32'h55);
    step(0, ins(1, 0, 7, 0), 32'h11C, 0, 0, 0, 0);
    step(0, ins(8, 1, 4, 0), 32'h120, 0, 0, 0, 0);
    step(0, ins(2, 4, 2, 0), 32'h124, 1, 1, 9, 32'h99);
    step(0, ins(1, 9, 4, 0), 32'h128, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 3) == 0 ? 6'd8 : 6'($urandom_range(0, 15));
      step($urandom_range(0, 49) == 0, {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)},
           $urandom, $urandom_range(0, 9) == 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
